// File: rtl/priority_arbiter_7seg.sv
// Eight-requester arbiter with hold/timeout/turnaround; owner index shown on a 7-segment digit.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the highest set request index wins.
module priority_arbiter_7seg #(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic       busy,
    output logic [6:0] segments,
    output logic       none
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] MAX_LAST  = 8'(MAX_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_own;
    logic [2:0] w_next_own;
    logic [2:0] w_win;
    logic [7:0] r_cnt;
    logic [7:0] w_next_cnt;
    logic       w_release;
    logic [7:0] r_grant;
    logic [7:0] w_next_grant;
    logic [6:0] r_seg;
    logic [6:0] w_next_seg;
    logic       r_none;
    logic       w_next_none;

    function automatic logic [6:0] seg_code(input logic [2:0] idx);
        logic [6:0] code;
        case (idx)
            3'd0:    code = 7'h3F;
            3'd1:    code = 7'h06;
            3'd2:    code = 7'h5B;
            3'd3:    code = 7'h4F;
            3'd4:    code = 7'h66;
            3'd5:    code = 7'h6D;
            3'd6:    code = 7'h7D;
            default: code = 7'h07;
        endcase
        return code;
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] r_ptr;

    // Scan from the farthest candidate inward so the nearest one below ptr wins; ptr itself is last.
    always_comb begin
        w_win = r_ptr;
        for (int j = 8; j >= 1; j--) begin
            if (req[r_ptr - 3'(j)]) begin
                w_win = r_ptr - 3'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd0;
        end else if (r_state == S_IDLE && (|req)) begin
            r_ptr <= w_win;
        end
    end
`else
    always_comb begin
        w_win = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                w_win = 3'(i);
            end
        end
    end
`endif

    assign w_release = ((r_cnt >= HOLD_LAST) && !req[r_own]) || (r_cnt == MAX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_own   <= 3'd0;
            r_cnt   <= 8'd0;
            r_grant <= 8'd0;
            r_seg   <= 7'd0;
            r_none  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_own   <= w_next_own;
            r_cnt   <= w_next_cnt;
            r_grant <= w_next_grant;
            r_seg   <= w_next_seg;
            r_none  <= w_next_none;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_own   = r_own;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next_state = S_GRANT;
                    w_next_own   = w_win;
                    w_next_cnt   = 8'd0;
                end
            end
            S_GRANT: begin
                w_next_cnt = r_cnt + 8'd1;
                if (w_release) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so all of them register on the same edge.
    always_comb begin
        w_next_grant = 8'd0;
        w_next_seg   = 7'd0;
        w_next_none  = 1'b1;
        if (w_next_state == S_GRANT) begin
            w_next_grant = 8'd1 << w_next_own;
            w_next_seg   = seg_code(w_next_own);
            w_next_none  = 1'b0;
        end
    end

    assign grant    = r_grant;
    assign busy     = |r_grant;
    assign segments = r_seg;
    assign none     = r_none;

endmodule

// File: tb/tb_priority_arbiter_7seg.sv
// Randomized and directed bench for priority_arbiter_7seg against a grant-width level model.
// Two instances: defaults (4/16) and a short one (HOLD 1, MAX 4).
module tb_priority_arbiter_7seg;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req   = 8'h00;
    logic [7:0] grant_a, grant_b;
    logic       busy_a, busy_b;
    logic [6:0] seg_a, seg_b;
    logic       none_a, none_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    priority_arbiter_7seg #(.HOLD_CYCLES(4), .MAX_CYCLES(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant_a), .busy(busy_a), .segments(seg_a), .none(none_a)
    );

    priority_arbiter_7seg #(.HOLD_CYCLES(1), .MAX_CYCLES(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant_b), .busy(busy_b), .segments(seg_b), .none(none_b)
    );

    // Model: owner (-1 when none), cycles held so far, dead cycles left before arbitration.
    int         m_owner[2];
    int         m_held[2];
    int         m_cool[2];
    int         m_last[2];
    int         HOLDV[2] = '{4, 1};
    int         MAXV[2]  = '{16, 4};
    logic [6:0] SEG[8]   = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    function automatic int pick(input logic [7:0] r, input int last);
        int idx;
        for (int j = 1; j <= 8; j++) begin
`ifdef ARB_ROUND_ROBIN_EN
            idx = (last - j + 16) % 8;
`else
            idx = 8 - j + (last - last);
`endif
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1;
            m_held[u]  = 0;
            m_cool[u]  = 0;
            m_last[u]  = 0;
        end
    endtask

    task automatic model_step(input int u);
        if (m_owner[u] >= 0) begin
            m_held[u]++;
            if ((m_held[u] >= HOLDV[u] && !req[m_owner[u]]) || m_held[u] == MAXV[u]) begin
                m_owner[u] = -1;
                m_cool[u]  = 1;
            end
        end else if (m_cool[u] > 0) begin
            m_cool[u]--;
        end else if (req != 8'h00) begin
            m_owner[u] = pick(req, m_last[u]);
            m_last[u]  = m_owner[u];
            m_held[u]  = 0;
        end
    endtask

    task automatic compare(input int u, input logic [7:0] g, input logic b,
                           input logic [6:0] s, input logic n);
        logic [7:0] eg;
        logic [6:0] es;
        logic       en;
        eg = 8'd0;
        es = 7'd0;
        en = 1'b1;
        if (m_owner[u] >= 0) begin
            eg = 8'd1 << m_owner[u];
            es = SEG[m_owner[u]];
            en = 1'b0;
        end
        n_checks++;
        if (g !== eg || b !== (eg != 8'd0) || s !== es || n !== en) begin
            n_errors++;
            $display("FAIL model_cmp[%0d] t=%0t: got grant=%h busy=%b seg=%h none=%b, want grant=%h busy=%b seg=%h none=%b",
                     u, $time, g, b, s, n, eg, (eg != 8'd0), es, en);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Compare on the falling edge, then advance the model across the coming rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            compare(0, grant_a, busy_a, seg_a, none_a);
            compare(1, grant_b, busy_b, seg_b, none_b);
            if (rst_n) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic drive(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (8) drive(8'h00);
    endtask

    logic [7:0] s_g[64];
    logic [6:0] s_s[64];
    logic [7:0] starts[$];
    logic [6:0] start_seg[$];
    int         cnt;
    int         bad;
    logic [7:0] r;

    task automatic record(input logic [7:0] r_in, input int n);
        starts.delete();
        start_seg.delete();
        for (int i = 0; i < n; i++) begin
            drive(r_in);
            s_g[i] = grant_a;
            s_s[i] = seg_a;
            if (grant_a != 8'h00 && (i == 0 || s_g[i-1] == 8'h00)) begin
                starts.push_back(grant_a);
                start_seg.push_back(seg_a);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_grant", grant_a, 8'h00);
        check("reset_none", none_a, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(8'h00);
            check("idle_grant", grant_a, 8'h00);
            check("idle_seg_none", {seg_a, none_a, busy_a}, {7'h00, 1'b1, 1'b0});
        end

        // Single request held 3 cycles: grant lasts the minimum hold of 4.
        settle();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(i < 3 ? 8'h20 : 8'h00);
            if (grant_a == 8'h20) begin
                cnt++;
                check("single_seg", {seg_a, none_a}, {7'h6D, 1'b0});
            end
        end
        check("single_width", cnt, 4);
        check("single_after", {seg_a, none_a}, {7'h00, 1'b1});

        // Timeout with a permanent request.
        settle();
        record(8'h01, 40);
        cnt = 0;
        while (cnt < 40 && s_g[cnt] == 8'h01) cnt++;
        check("timeout_width", cnt, 16);
        check("timeout_gap0", s_g[16], 8'h00);
        check("timeout_gap1", s_g[17], 8'h00);
        check("timeout_regrant", s_g[18], 8'h01);
        bad = 0;
        for (int i = 0; i < 16; i++) if (s_s[i] != 7'h3F) bad++;
        check("timeout_seg", bad, 0);

        // Contention between requesters 7 and 4.
        settle();
        record(8'h90, 60);
        check("contend_count", (starts.size() >= 3), 1);
        if (starts.size() >= 3) begin
            check("contend_first", starts[0], 8'h80);
            check("contend_first_seg", start_seg[0], 7'h07);
`ifdef ARB_ROUND_ROBIN_EN
            check("contend_second", starts[1], 8'h10);
            check("contend_second_seg", start_seg[1], 7'h66);
`else
            check("contend_second", starts[1], 8'h80);
            check("contend_second_seg", start_seg[1], 7'h07);
`endif
            check("contend_third", starts[2], 8'h80);
        end

        // Asynchronous reset in grant cycle 2.
        settle();
        repeat (3) drive(8'h04);
        check("rstmid_before", grant_a, 8'h04);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_grant", grant_a, 8'h00);
        check("rstmid_none_busy_seg", {none_a, busy_a, seg_a}, {1'b1, 1'b0, 7'h00});
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rstmid_held", grant_a, 8'h00);
        drive(8'h04);
        check("rstmid_regrant", grant_a, 8'h04);

        // Non-preemption: requester 7 arrives while 2 owns the grant.
        settle();
        drive(8'h04);
        check("nopre_first", grant_a, 8'h04);
        record(8'h84, 40);
        cnt = 0;
        while (cnt < 40 && s_g[cnt] == 8'h04) cnt++;
        check("nopre_width", cnt, 15);
        check("nopre_next_count", (starts.size() >= 2), 1);
        if (starts.size() >= 2) check("nopre_next", starts[1], 8'h80);

        // HOLD_CYCLES = 1 with the request gone in the first grant cycle.
        settle();
        drive(8'h08);
        check("hold1_on", grant_b, 8'h08);
        drive(8'h00);
        check("hold1_off", grant_b, 8'h00);
        check("hold4_still_on", grant_a, 8'h08);

        // Random traffic with occasional asynchronous resets.
        settle();
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r = 8'h00;
                    1:       r = 8'($urandom);
                    2:       r = 8'd1 << $urandom_range(0, 7);
                    default: r = 8'($urandom) & 8'($urandom);
                endcase
            end
            drive(r);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
